// File: rtl/anita_trig_pkg.sv
// Shared constants for the ANITA L1 trigger router: L1 line positions, output
// indices, config register addresses and CTRL bit positions.
package anita_trig_pkg;

    localparam int LINES_PER_SRC = 8;
    localparam int OUTS_PER_SRC  = 6;

    // L1 line position within an 8-line source group (bits 2,3 are unused)
    localparam int TOP_RCP_BIT = 0;
    localparam int TOP_LCP_BIT = 1;
    localparam int MID_RCP_BIT = 4;
    localparam int MID_LCP_BIT = 5;
    localparam int BOT_RCP_BIT = 6;
    localparam int BOT_LCP_BIT = 7;

    // Output index within a source; RCP is always even, LCP is always odd
    localparam int OUT_TOP_RCP = 0;
    localparam int OUT_TOP_LCP = 1;
    localparam int OUT_MID_RCP = 2;
    localparam int OUT_MID_LCP = 3;
    localparam int OUT_BOT_RCP = 4;
    localparam int OUT_BOT_LCP = 5;

    localparam logic [1:0] ADDR_TRIG_MASK = 2'd0;
    localparam logic [1:0] ADDR_SCAL_MASK = 2'd1;
    localparam logic [1:0] ADDR_STRETCH   = 2'd2;
    localparam logic [1:0] ADDR_CTRL      = 2'd3;

    localparam int CTRL_SWAP_POL_BIT   = 0;
    localparam int CTRL_STRETCH_EN_BIT = 1;

    function automatic int line_bit(input int out_idx);
        int pos;
        case (out_idx)
            OUT_TOP_RCP: pos = TOP_RCP_BIT;
            OUT_TOP_LCP: pos = TOP_LCP_BIT;
            OUT_MID_RCP: pos = MID_RCP_BIT;
            OUT_MID_LCP: pos = MID_LCP_BIT;
            OUT_BOT_RCP: pos = BOT_RCP_BIT;
            OUT_BOT_LCP: pos = BOT_LCP_BIT;
            default:     pos = TOP_RCP_BIT;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/anita_trig_stretch.sv
// One router channel: two-stage input pipeline, rising-edge detect, retriggerable
// stretch down-counter for the trigger copy and a single-cycle scaler pulse.
module anita_trig_stretch
    import anita_trig_pkg::*;
#(
    parameter int STRETCH_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig_line,
    input  logic                 scal_line,
    input  logic [STRETCH_W-1:0] stretch_len,
    input  logic                 stretch_en,
    input  logic                 trig_mask,
    input  logic                 scal_mask,
    output logic                 trig_out,
    output logic                 scal_out
);

    logic                 trig_q;
    logic                 trig_qq;
    logic                 scal_q;
    logic                 scal_qq;
    logic                 trig_rise;
    logic                 scal_rise;
    logic                 stretch_mode;
    logic [STRETCH_W-1:0] cnt;
    logic [STRETCH_W-1:0] cnt_next;

    assign trig_rise    = trig_q & ~trig_qq;
    assign scal_rise    = scal_q & ~scal_qq;
    assign stretch_mode = stretch_en && (stretch_len != '0);

    // A rise reloads even on the cycle the count would expire.
    always_comb begin
        cnt_next = cnt;
        if (trig_rise) begin
            cnt_next = stretch_len;
        end else if (cnt != '0) begin
            cnt_next = cnt - STRETCH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q   <= 1'b0;
            trig_qq  <= 1'b0;
            scal_q   <= 1'b0;
            scal_qq  <= 1'b0;
            cnt      <= '0;
            trig_out <= 1'b0;
            scal_out <= 1'b0;
        end else begin
            trig_q   <= trig_line;
            trig_qq  <= trig_q;
            scal_q   <= scal_line;
            scal_qq  <= scal_q;
            cnt      <= cnt_next;
            // Counter keeps running under mask so unmasking resumes the pulse.
            trig_out <= ~trig_mask & (stretch_mode ? (cnt_next != '0) : trig_q);
            scal_out <= ~scal_mask & scal_rise;
        end
    end

endmodule

// File: rtl/anita_trigger_router.sv
// Routes NSRC groups of L1 lines onto top/mid/bot x RCP/LCP trigger and scaler
// buses, with config registers for masking, polarity swap and pulse stretching.
module anita_trigger_router
    import anita_trig_pkg::*;
#(
    parameter int NSRC      = 2,
    parameter int STRETCH_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [8*NSRC-1:0]    trig_i,
    input  logic [8*NSRC-1:0]    scal_i,
    input  logic                 cfg_wr_i,
    input  logic [1:0]           cfg_addr_i,
    input  logic [31:0]          cfg_dat_i,
    output logic [31:0]          cfg_dat_o,
    output logic [NSRC-1:0]      top_rcp_o,
    output logic [NSRC-1:0]      top_lcp_o,
    output logic [NSRC-1:0]      mid_rcp_o,
    output logic [NSRC-1:0]      mid_lcp_o,
    output logic [NSRC-1:0]      bot_rcp_o,
    output logic [NSRC-1:0]      bot_lcp_o,
    output logic [NSRC-1:0]      top_rcp_scaler_o,
    output logic [NSRC-1:0]      top_lcp_scaler_o,
    output logic [NSRC-1:0]      mid_rcp_scaler_o,
    output logic [NSRC-1:0]      mid_lcp_scaler_o,
    output logic [NSRC-1:0]      bot_rcp_scaler_o,
    output logic [NSRC-1:0]      bot_lcp_scaler_o
);

    localparam int NOUT = OUTS_PER_SRC * NSRC;

    logic [NOUT-1:0]      trig_mask;
    logic [NOUT-1:0]      scal_mask;
    logic [STRETCH_W-1:0] stretch_len;
    logic                 swap_pol;
    logic                 stretch_en;
    logic [31:0]          rd_dat;

    logic [NOUT-1:0]      trig_map;
    logic [NOUT-1:0]      scal_map;
    logic [NOUT-1:0]      trig_out;
    logic [NOUT-1:0]      scal_out;

    // Lines 2,3 of each group and the high data bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{trig_i, scal_i, cfg_dat_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_mask   <= '0;
            scal_mask   <= '0;
            stretch_len <= '0;
            swap_pol    <= 1'b0;
            stretch_en  <= 1'b0;
        end else if (cfg_wr_i) begin
            case (cfg_addr_i)
                ADDR_TRIG_MASK: trig_mask   <= cfg_dat_i[NOUT-1:0];
                ADDR_SCAL_MASK: scal_mask   <= cfg_dat_i[NOUT-1:0];
                ADDR_STRETCH:   stretch_len <= cfg_dat_i[STRETCH_W-1:0];
                ADDR_CTRL: begin
                    swap_pol   <= cfg_dat_i[CTRL_SWAP_POL_BIT];
                    stretch_en <= cfg_dat_i[CTRL_STRETCH_EN_BIT];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_dat = '0;
        case (cfg_addr_i)
            ADDR_TRIG_MASK: rd_dat[NOUT-1:0]      = trig_mask;
            ADDR_SCAL_MASK: rd_dat[NOUT-1:0]      = scal_mask;
            ADDR_STRETCH:   rd_dat[STRETCH_W-1:0] = stretch_len;
            ADDR_CTRL: begin
                rd_dat[CTRL_SWAP_POL_BIT]   = swap_pol;
                rd_dat[CTRL_STRETCH_EN_BIT] = stretch_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_dat_o <= '0;
        end else begin
            cfg_dat_o <= rd_dat;
        end
    end

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        for (genvar j = 0; j < OUTS_PER_SRC; j++) begin : g_out
            localparam int IDX     = OUTS_PER_SRC * k + j;
            localparam int LN_NORM = LINES_PER_SRC * k + line_bit(j);
            // j^1 is the opposite-polarity partner of the same antenna ring
            localparam int LN_SWAP = LINES_PER_SRC * k + line_bit(j ^ 1);

            assign trig_map[IDX] = swap_pol ? trig_i[LN_SWAP] : trig_i[LN_NORM];
            assign scal_map[IDX] = swap_pol ? scal_i[LN_SWAP] : scal_i[LN_NORM];

            anita_trig_stretch #(
                .STRETCH_W (STRETCH_W)
            ) u_chan (
                .clk         (clk_i),
                .rst         (rst_i),
                .trig_line   (trig_map[IDX]),
                .scal_line   (scal_map[IDX]),
                .stretch_len (stretch_len),
                .stretch_en  (stretch_en),
                .trig_mask   (trig_mask[IDX]),
                .scal_mask   (scal_mask[IDX]),
                .trig_out    (trig_out[IDX]),
                .scal_out    (scal_out[IDX])
            );
        end

        assign top_rcp_o[k]        = trig_out[OUTS_PER_SRC*k + OUT_TOP_RCP];
        assign top_lcp_o[k]        = trig_out[OUTS_PER_SRC*k + OUT_TOP_LCP];
        assign mid_rcp_o[k]        = trig_out[OUTS_PER_SRC*k + OUT_MID_RCP];
        assign mid_lcp_o[k]        = trig_out[OUTS_PER_SRC*k + OUT_MID_LCP];
        assign bot_rcp_o[k]        = trig_out[OUTS_PER_SRC*k + OUT_BOT_RCP];
        assign bot_lcp_o[k]        = trig_out[OUTS_PER_SRC*k + OUT_BOT_LCP];
        assign top_rcp_scaler_o[k] = scal_out[OUTS_PER_SRC*k + OUT_TOP_RCP];
        assign top_lcp_scaler_o[k] = scal_out[OUTS_PER_SRC*k + OUT_TOP_LCP];
        assign mid_rcp_scaler_o[k] = scal_out[OUTS_PER_SRC*k + OUT_MID_RCP];
        assign mid_lcp_scaler_o[k] = scal_out[OUTS_PER_SRC*k + OUT_MID_LCP];
        assign bot_rcp_scaler_o[k] = scal_out[OUTS_PER_SRC*k + OUT_BOT_RCP];
        assign bot_lcp_scaler_o[k] = scal_out[OUTS_PER_SRC*k + OUT_BOT_LCP];
    end

endmodule

// File: tb/tb_anita_trigger_router.sv
// Directed bench for anita_trigger_router with NSRC=2, STRETCH_W=4.
module tb_anita_trigger_router;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] trig_i;
    logic [15:0] scal_i;
    logic        cfg_wr_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_dat_i;
    logic [31:0] cfg_dat_o;
    logic [1:0]  top_rcp_o, top_lcp_o, mid_rcp_o, mid_lcp_o, bot_rcp_o, bot_lcp_o;
    logic [1:0]  top_rcp_scaler_o, top_lcp_scaler_o, mid_rcp_scaler_o;
    logic [1:0]  mid_lcp_scaler_o, bot_rcp_scaler_o, bot_lcp_scaler_o;

    logic [11:0] trig_all;
    logic [11:0] scal_all;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    anita_trigger_router #(
        .NSRC      (2),
        .STRETCH_W (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .trig_i           (trig_i),
        .scal_i           (scal_i),
        .cfg_wr_i         (cfg_wr_i),
        .cfg_addr_i       (cfg_addr_i),
        .cfg_dat_i        (cfg_dat_i),
        .cfg_dat_o        (cfg_dat_o),
        .top_rcp_o        (top_rcp_o),
        .top_lcp_o        (top_lcp_o),
        .mid_rcp_o        (mid_rcp_o),
        .mid_lcp_o        (mid_lcp_o),
        .bot_rcp_o        (bot_rcp_o),
        .bot_lcp_o        (bot_lcp_o),
        .top_rcp_scaler_o (top_rcp_scaler_o),
        .top_lcp_scaler_o (top_lcp_scaler_o),
        .mid_rcp_scaler_o (mid_rcp_scaler_o),
        .mid_lcp_scaler_o (mid_lcp_scaler_o),
        .bot_rcp_scaler_o (bot_rcp_scaler_o),
        .bot_lcp_scaler_o (bot_lcp_scaler_o)
    );

    // Flat view: bit 6k+j, j = top_rcp, top_lcp, mid_rcp, mid_lcp, bot_rcp, bot_lcp
    assign trig_all = {bot_lcp_o[1], bot_rcp_o[1], mid_lcp_o[1], mid_rcp_o[1],
                       top_lcp_o[1], top_rcp_o[1], bot_lcp_o[0], bot_rcp_o[0],
                       mid_lcp_o[0], mid_rcp_o[0], top_lcp_o[0], top_rcp_o[0]};
    assign scal_all = {bot_lcp_scaler_o[1], bot_rcp_scaler_o[1], mid_lcp_scaler_o[1],
                       mid_rcp_scaler_o[1], top_lcp_scaler_o[1], top_rcp_scaler_o[1],
                       bot_lcp_scaler_o[0], bot_rcp_scaler_o[0], mid_lcp_scaler_o[0],
                       mid_rcp_scaler_o[0], top_lcp_scaler_o[0], top_rcp_scaler_o[0]};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] dat);
        cfg_wr_i   = 1'b1;
        cfg_addr_i = addr;
        cfg_dat_i  = dat;
        tick();
        cfg_wr_i   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        cfg_addr_i = addr;
        tick();
        check_val(tag, cfg_dat_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hist0, hist1, hs10, hs11;

        // Reset with every input held high
        rst_i = 1'b1; trig_i = 16'hFFFF; scal_i = 16'hFFFF;
        cfg_wr_i = 1'b0; cfg_addr_i = 2'd0; cfg_dat_i = 32'h0;
        repeat (3) tick();
        check_val("rst_trig", 32'(trig_all), 32'h0);
        check_val("rst_scal", 32'(scal_all), 32'h0);
        check_val("rst_cfg", cfg_dat_o, 32'h0);
        rst_i = 1'b0;
        tick();
        check_val("post_rst1_scal", 32'(scal_all), 32'h0);
        check_val("post_rst1_trig", 32'(trig_all), 32'h0);
        tick();
        check_val("post_rst2_scal", 32'(scal_all), 32'hFFF);
        check_val("post_rst2_trig", 32'(trig_all), 32'hFFF);
        tick();
        check_val("post_rst3_scal", 32'(scal_all), 32'h0);
        check_val("post_rst3_trig", 32'(trig_all), 32'hFFF);

        // Address map, level mode
        trig_i = 16'h0; scal_i = 16'h0;
        repeat (3) tick();
        check_val("idle_trig", 32'(trig_all), 32'h0);
        trig_i = 16'h1000;
        tick();
        check_val("map_lat1", 32'(trig_all), 32'h0);
        tick();
        check_val("map_bit12", 32'(trig_all), 32'h100);
        check_val("map_mid_rcp1", 32'(mid_rcp_o), 32'h2);
        trig_i = 16'h0C0C; scal_i = 16'h0080;
        tick();
        check_val("scal_lat1", 32'(scal_all), 32'h0);
        tick();
        check_val("map_unused", 32'(trig_all), 32'h0);
        check_val("scal_bit7", 32'(scal_all), 32'h020);
        tick();
        check_val("scal_held_once", 32'(scal_all), 32'h0);
        trig_i = 16'h0; scal_i = 16'h0;
        repeat (3) tick();

        // Stretch of 5, single pulse then retrigger
        cfg_write(2'd2, 32'd5);
        cfg_write(2'd3, 32'h2);
        hist0 = '0;
        trig_i = 16'h0002;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) trig_i = 16'h0;
            tick();
            hist0[i] = trig_all[1];
        end
        check_val("stretch5_single", 32'(hist0), 32'h003E);
        hist0 = '0;
        trig_i = 16'h0002;
        for (int i = 0; i < 16; i++) begin
            if (i == 1 || i == 4) trig_i = 16'h0;
            if (i == 3) trig_i = 16'h0002;
            tick();
            hist0[i] = trig_all[1];
        end
        check_val("stretch5_retrig", 32'(hist0), 32'h01FE);

        // Masking, with trigger mask cleared mid-stretch
        cfg_write(2'd0, 32'h001);
        cfg_write(2'd1, 32'h800);
        hist0 = '0; hist1 = '0; hs10 = '0; hs11 = '0;
        trig_i = 16'h0003; scal_i = 16'hC000;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) begin trig_i = 16'h0; scal_i = 16'h0; end
            if (i == 2) begin cfg_wr_i = 1'b1; cfg_addr_i = 2'd0; cfg_dat_i = 32'h0; end
            if (i == 3) cfg_wr_i = 1'b0;
            tick();
            hist0[i] = trig_all[0];
            hist1[i] = trig_all[1];
            hs10[i]  = scal_all[10];
            hs11[i]  = scal_all[11];
        end
        check_val("mask_top_rcp0", 32'(hist0), 32'h0038);
        check_val("mask_top_lcp0", 32'(hist1), 32'h003E);
        check_val("mask_scal_bot_rcp1", 32'(hs10), 32'h0002);
        check_val("mask_scal_bot_lcp1", 32'(hs11), 32'h0000);
        cfg_write(2'd1, 32'h0);

        // Polarity swap, level mode
        cfg_write(2'd3, 32'h1);
        trig_i = 16'h0001;
        repeat (2) tick();
        check_val("swap_bit0", 32'(trig_all), 32'h002);
        trig_i = 16'h0080;
        repeat (2) tick();
        check_val("swap_bit7", 32'(trig_all), 32'h010);
        trig_i = 16'h0;
        repeat (2) tick();
        read_check("rd_ctrl", 2'd3, 32'h1);
        read_check("rd_stretch", 2'd2, 32'h5);
        cfg_write(2'd0, 32'hFFFF_FFFF);
        read_check("rd_mask_width", 2'd0, 32'hFFF);
        cfg_write(2'd0, 32'h0);
        cfg_write(2'd2, 32'hFFFF_FFFF);
        read_check("rd_stretch_width", 2'd2, 32'hF);

        // Reset during a 15-cycle stretch
        cfg_write(2'd3, 32'h2);
        trig_i = 16'h0001;
        tick();
        trig_i = 16'h0;
        tick();
        repeat (3) tick();
        check_val("stretch15_active", 32'(trig_all), 32'h001);
        rst_i = 1'b1;
        tick();
        check_val("rst_trunc_trig", 32'(trig_all), 32'h0);
        check_val("rst_trunc_cfg", cfg_dat_o, 32'h0);
        rst_i = 1'b0;
        tick();
        check_val("rst_trunc_after", 32'(trig_all), 32'h0);
        read_check("rd0_after_rst", 2'd0, 32'h0);
        read_check("rd1_after_rst", 2'd1, 32'h0);
        read_check("rd2_after_rst", 2'd2, 32'h0);
        read_check("rd3_after_rst", 2'd3, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
